// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch controller:
//   sw_state_e    - controller state encoding (IDLE, RUN, PAUSE, LAP), 2 bits
//   SEC_ONES_MAX  - last value of the seconds-ones BCD digit
//   SEC_TENS_MAX  - last value of the seconds-tens BCD digit
//   presc_width() - prescaler counter width for a given division ratio
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Width needed to hold 0..div-1; never less than one bit.
  function automatic int presc_width(input int div);
    if (div <= 2) return 1;
    return $clog2(div);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_if
// Button inputs and display/status outputs of the stopwatch controller.
//   start_stop, lap, clr          - debounced level buttons (to controller)
//   running, frozen, tick, wrap   - status flags (from controller)
//   sec_ones, sec_tens, minutes   - BCD display digits M:SS (from controller)
// Modports:
//   master - the side that presses buttons and observes the display
//   slave  - the controller itself
// -----------------------------------------------------------------------------
interface stopwatch_ctrl_if;

  logic       start_stop;
  logic       lap;
  logic       clr;
  logic       running;
  logic       frozen;
  logic       tick;
  logic       wrap;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] minutes;

  modport master (
    output start_stop, lap, clr,
    input  running, frozen, tick, wrap, sec_ones, sec_tens, minutes
  );

  modport slave (
    input  start_stop, lap, clr,
    output running, frozen, tick, wrap, sec_ones, sec_tens, minutes
  );

endinterface

// File: rtl/stopwatch_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler producing a one-per-DIV-cycles advance strobe as a clock enable.
// Ports:
//   clk, reset - system clock, asynchronous active-high reset
//   en_i       - count enable (counter holds its value when low)
//   clr_i      - synchronous clear of the counter (wins over en_i)
//   adv_o      - combinational: this edge is the terminal count, advance now
//   tick_o     - registered one-cycle pulse following each advance
// -----------------------------------------------------------------------------
module tick_gen
  import stopwatch_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic adv_o,
  output logic tick_o
);

  localparam int            W    = presc_width(DIV);
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic         tick_q;

  assign adv_o  = en_i & ~clr_i & (cnt_q == LAST);
  assign tick_o = tick_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= adv_o;
      if (clr_i || adv_o) begin
        cnt_q <= '0;
      end else if (en_i) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Start/pause/lap/clear stopwatch with BCD M:SS count driven by a tick enable.
// Ports:
//   clk    - system clock (the only clock; counting uses an enable)
//   reset  - asynchronous active-high reset
//   sw     - stopwatch_ctrl_if.slave: buttons in, status and digits out
// Parameters:
//   CLK_HZ / TICK_HZ - division ratio DIV (integer, >= 2)
//   MAX_MIN          - last minutes value before the count wraps (1..9)
// -----------------------------------------------------------------------------
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1,
  parameter int MAX_MIN = 9
) (
  input  logic              clk,
  input  logic              reset,
  stopwatch_ctrl_if.slave   sw
);

  localparam int         DIV     = CLK_HZ / TICK_HZ;
  localparam logic [3:0] MIN_MAX = 4'(MAX_MIN);

  // Button edge detection. armed_q masks edges on the first clock after reset
  // so a button already held through reset release is not seen as a press.
  logic [2:0] btn;
  logic [2:0] btn_q;
  logic [2:0] btn_edge;
  logic       armed_q;

  assign btn      = {sw.clr, sw.lap, sw.start_stop};
  assign btn_edge = btn & ~btn_q & {3{armed_q}};

  logic ss_e, lap_e, clr_e;
  assign ss_e  = btn_edge[0];
  assign lap_e = btn_edge[1];
  assign clr_e = btn_edge[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      btn_q   <= btn;
      armed_q <= 1'b1;
    end
  end

  // Controller state with registered status outputs.
  sw_state_e state_q;
  logic      running_q;
  logic      frozen_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      frozen_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_e) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (ss_e) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end else if (lap_e) begin
            state_q  <= LAP;
            frozen_q <= 1'b1;
          end
        end
        LAP: begin
          if (ss_e) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
            frozen_q  <= 1'b0;
          end else if (lap_e) begin
            state_q  <= RUN;
            frozen_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (clr_e) begin
            state_q <= IDLE;
          end else if (ss_e) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          frozen_q  <= 1'b0;
        end
      endcase
    end
  end

  // Prescaler control. A start_stop edge leaving RUN/LAP suppresses counting on
  // that same edge, so a pause on the terminal cycle produces no tick.
  logic counting;
  logic clear_live;
  logic presc_en;
  logic presc_clr;
  logic adv;
  logic tick;

  assign counting   = (state_q == RUN) || (state_q == LAP);
  assign clear_live = (state_q == PAUSE) && clr_e;
  assign presc_en   = counting && !ss_e;
  assign presc_clr  = (state_q == IDLE) || clear_live;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .en_i   (presc_en),
    .clr_i  (presc_clr),
    .adv_o  (adv),
    .tick_o (tick)
  );

  // Live BCD count, wrap pulse and lap latch.
  logic [3:0] ones_q, tens_q, min_q;
  logic [3:0] lap_ones_q, lap_tens_q, lap_min_q;
  logic       wrap_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones_q <= '0;
      tens_q <= '0;
      min_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (clear_live) begin
        ones_q <= '0;
        tens_q <= '0;
        min_q  <= '0;
      end else if (adv) begin
        if (ones_q == SEC_ONES_MAX) begin
          ones_q <= '0;
          if (tens_q == SEC_TENS_MAX) begin
            tens_q <= '0;
            if (min_q == MIN_MAX) begin
              min_q  <= '0;
              wrap_q <= 1'b1;
            end else begin
              min_q <= min_q + 4'd1;
            end
          end else begin
            tens_q <= tens_q + 4'd1;
          end
        end else begin
          ones_q <= ones_q + 4'd1;
        end
      end
    end
  end

  // Capture the pre-advance count on the RUN->LAP edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_ones_q <= '0;
      lap_tens_q <= '0;
      lap_min_q  <= '0;
    end else if ((state_q == RUN) && lap_e && !ss_e) begin
      lap_ones_q <= ones_q;
      lap_tens_q <= tens_q;
      lap_min_q  <= min_q;
    end
  end

  assign sw.running  = running_q;
  assign sw.frozen   = frozen_q;
  assign sw.tick     = tick;
  assign sw.wrap     = wrap_q;
  assign sw.sec_ones = frozen_q ? lap_ones_q : ones_q;
  assign sw.sec_tens = frozen_q ? lap_tens_q : tens_q;
  assign sw.minutes  = frozen_q ? lap_min_q  : min_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed bench for stopwatch_ctrl with DIV=10, MAX_MIN=9. A table of button
// presses with hand-computed expected outputs, followed by hand-written
// sequences for the M:SS wrap and an asynchronous reset with a held button.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .CLK_HZ  (10),
    .TICK_HZ (1),
    .MAX_MIN (9)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw_if)
  );

  int checks = 0;
  int errors = 0;
  int tick_count = 0;
  int wrap_count = 0;

  // Pulse counters; a one-cycle pulse is seen on exactly one falling edge.
  always @(negedge clk) begin
    if (sw_if.tick) tick_count++;
    if (sw_if.wrap) wrap_count++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string ctx, input int run, input int frz,
                               input int tk, input int wr, input int mm,
                               input int st, input int so);
    check({ctx, " running"},  int'(sw_if.running),  run);
    check({ctx, " frozen"},   int'(sw_if.frozen),   frz);
    check({ctx, " tick"},     int'(sw_if.tick),     tk);
    check({ctx, " wrap"},     int'(sw_if.wrap),     wr);
    check({ctx, " minutes"},  int'(sw_if.minutes),  mm);
    check({ctx, " sec_tens"}, int'(sw_if.sec_tens), st);
    check({ctx, " sec_ones"}, int'(sw_if.sec_ones), so);
  endtask

  // Row: buttons held for one edge, released, then w more edges before compare.
  // nt = tick pulses completed before the compare cycle since the table began.
  typedef struct {
    int ss, lp, cl, w;
    int run, frz, tk, wr;
    int mm, st, so;
    int nt;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];
  int   tick_base;

  initial begin
    //            ss lp cl   w  run frz tk wr  mm st so  nt
    vecs[0]  = '{0, 0, 0,   2,  0, 0, 0, 0,  0, 0, 0,  0};  // idle after reset
    vecs[1]  = '{1, 0, 0,   0,  1, 0, 0, 0,  0, 0, 0,  0};  // start -> RUN
    vecs[2]  = '{0, 0, 0,   8,  1, 0, 0, 0,  0, 0, 0,  0};  // 9 cycles in, no tick
    vecs[3]  = '{0, 0, 0,   0,  1, 0, 1, 0,  0, 0, 1,  0};  // first tick at 10
    vecs[4]  = '{0, 0, 0,  59,  1, 0, 1, 0,  0, 0, 7,  6};  // 0:07
    vecs[5]  = '{0, 1, 0,   0,  1, 1, 0, 0,  0, 0, 7,  7};  // lap at 0:07
    vecs[6]  = '{0, 0, 0, 299,  1, 1, 0, 0,  0, 0, 7, 37};  // frozen for 30 s
    vecs[7]  = '{0, 1, 0,   0,  1, 0, 0, 0,  0, 3, 7, 37};  // release -> 0:37
    vecs[8]  = '{0, 0, 0,   7,  1, 0, 1, 0,  0, 3, 8, 37};  // tick to 0:38
    vecs[9]  = '{0, 0, 0,   3,  1, 0, 0, 0,  0, 3, 8, 38};  // prescaler at 4
    vecs[10] = '{1, 0, 0,   0,  0, 0, 0, 0,  0, 3, 8, 38};  // pause
    vecs[11] = '{0, 0, 0,  99,  0, 0, 0, 0,  0, 3, 8, 38};  // no ticks paused
    vecs[12] = '{1, 0, 0,   4,  1, 0, 0, 0,  0, 3, 8, 38};  // resume +4
    vecs[13] = '{0, 0, 0,   0,  1, 0, 0, 0,  0, 3, 8, 38};  // resume +5
    vecs[14] = '{0, 0, 0,   0,  1, 0, 1, 0,  0, 3, 9, 38};  // tick at resume +6
    vecs[15] = '{0, 0, 1,   0,  1, 0, 0, 0,  0, 3, 9, 39};  // clr ignored in RUN
    vecs[16] = '{0, 1, 0,   0,  1, 1, 0, 0,  0, 3, 9, 39};  // lap at 0:39
    vecs[17] = '{0, 0, 0,  30,  1, 1, 0, 0,  0, 3, 9, 42};  // live 0:42 beneath
    vecs[18] = '{1, 0, 0,   1,  0, 0, 0, 0,  0, 4, 2, 42};  // LAP->PAUSE shows live
    vecs[19] = '{1, 0, 1,   1,  0, 0, 0, 0,  0, 0, 0, 42};  // clr beats start_stop
    vecs[20] = '{0, 0, 1,   3,  0, 0, 0, 0,  0, 0, 0, 42};  // clr ignored in IDLE
    vecs[21] = '{1, 1, 0,   1,  1, 0, 0, 0,  0, 0, 0, 42};  // IDLE start
    vecs[22] = '{1, 1, 0,   0,  0, 0, 0, 0,  0, 0, 0, 42};  // start_stop beats lap
    vecs[23] = '{0, 0, 1,   0,  0, 0, 0, 0,  0, 0, 0, 42};  // clr -> IDLE
    vecs[24] = '{1, 0, 0,   9,  1, 0, 0, 0,  0, 0, 0, 42};  // prescaler at 9
    vecs[25] = '{1, 0, 0,   1,  0, 0, 0, 0,  0, 0, 0, 42};  // pause on terminal
    vecs[26] = '{1, 0, 0,   0,  1, 0, 0, 0,  0, 0, 0, 42};  // resume
    vecs[27] = '{0, 0, 0,   0,  1, 0, 1, 0,  0, 0, 1, 42};  // held partial second
    vecs[28] = '{1, 0, 0,   0,  0, 0, 0, 0,  0, 0, 1, 43};  // pause
    vecs[29] = '{0, 0, 1,   0,  0, 0, 0, 0,  0, 0, 0, 43};  // clear

    sw_if.start_stop = 1'b0;
    sw_if.lap        = 1'b0;
    sw_if.clr        = 1'b0;
    reset            = 1'b1;

    // Reset state
    repeat (3) step();
    check_outputs("reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick_base = tick_count;

    // Table-driven part
    for (int i = 0; i < NV; i++) begin
      sw_if.start_stop = vecs[i].ss[0];
      sw_if.lap        = vecs[i].lp[0];
      sw_if.clr        = vecs[i].cl[0];
      step();
      sw_if.start_stop = 1'b0;
      sw_if.lap        = 1'b0;
      sw_if.clr        = 1'b0;
      repeat (vecs[i].w) step();
      check_outputs($sformatf("row%0d", i), vecs[i].run, vecs[i].frz,
                    vecs[i].tk, vecs[i].wr, vecs[i].mm, vecs[i].st, vecs[i].so);
      check($sformatf("row%0d tick_count", i), tick_count - tick_base, vecs[i].nt);
    end

    // Wrap from 9:59 to 0:00
    sw_if.start_stop = 1'b1;
    step();
    sw_if.start_stop = 1'b0;
    repeat (5950) step();
    check_outputs("595 ticks", 1, 0, 1, 0, 9, 5, 5);
    repeat (49) step();
    check_outputs("9:59", 1, 0, 0, 0, 9, 5, 9);
    step();
    check_outputs("wrap edge", 1, 0, 1, 1, 0, 0, 0);
    step();
    check_outputs("after wrap", 1, 0, 0, 0, 0, 0, 0);
    check("wrap_count", wrap_count, 1);

    // Asynchronous reset at 3:21 with start_stop held
    repeat (2009) step();
    check_outputs("3:21", 1, 0, 1, 0, 3, 2, 1);
    sw_if.start_stop = 1'b1;
    reset = 1'b1;
    #2;
    check_outputs("async reset", 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    reset = 1'b0;
    repeat (5) step();
    check_outputs("held through reset", 0, 0, 0, 0, 0, 0, 0);
    sw_if.start_stop = 1'b0;
    step();
    check("released running", int'(sw_if.running), 0);
    sw_if.start_stop = 1'b1;
    step();
    sw_if.start_stop = 1'b0;
    check("repress running", int'(sw_if.running), 1);
    check("final wrap_count", wrap_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Controller that sequences the 1 Hz seconds counting datapath for the lab-4 display.
- Owns the prescaler (tick generation) and a start/pause/lap/clear state machine.
- Drives BCD digits (M:SS) to the seven-segment display mux.
- Replaces free-running clock division with a single-clock tick-enable scheme; no derived clocks.

Parameters:
- CLK_HZ, 100000000, input clock frequency.
- TICK_HZ, 1, count rate. DIV = CLK_HZ/TICK_HZ, which must be an integer >= 2.
- MAX_MIN, 9, highest minutes value before wrap; range 1..9.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_stop  in  1  debounced level button; acts on rising edge.
- lap  in  1  debounced level button; acts on rising edge.
- clr  in  1  debounced level button; acts on rising edge.
- running  out  1  high in RUN or LAP.
- frozen  out  1  high in LAP; digit outputs show the lap latch.
- tick  out  1  one-cycle pulse on each counted second.
- wrap  out  1  one-cycle pulse when M:SS rolls from MAX_MIN:59 to 0:00.
- sec_ones  out  4  BCD 0..9.
- sec_tens  out  4  BCD 0..5.
- minutes  out  4  BCD 0..MAX_MIN.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high; all flops clear immediately, including mid-count.
- Reset values: state=IDLE, prescaler=0, all digits=0, lap latch=0, running=0, frozen=0, tick=0, wrap=0, button history regs=0.
- Button edge detection: edge = btn & ~btn_q, where btn_q is the registered previous value.
  - A button held high through reset release does not generate an edge.
  - The state changes on the clock edge at which the button edge is detected.
- States:
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> PAUSE; lap -> LAP, capturing the current digits into the lap latch on that edge.
  - LAP: lap -> RUN (latch released); start_stop -> PAUSE.
  - PAUSE: start_stop -> RUN; clr -> IDLE, zeroing the digits and prescaler.
- Priority when edges occur in the same cycle:
  - start_stop beats lap.
  - In PAUSE, clr beats start_stop.
  - clr is ignored in IDLE, RUN and LAP.
- Prescaler:
  - Counts 0..DIV-1 only in RUN/LAP.
  - Holds its value in PAUSE, so resuming continues the partial second.
  - Held at 0 in IDLE.
- Tick timing:
  - On the edge where the prescaler equals DIV-1 in RUN/LAP, the prescaler returns to 0, the digits advance, and tick (a registered output) goes high for exactly one cycle.
  - The first tick is DIV cycles after entry to RUN from IDLE.
- Counting (BCD, no binary intermediate):
  - sec_ones 9->0 with carry.
  - sec_tens 5->0 with carry.
  - minutes MAX_MIN->0, with wrap asserted in the same cycle as tick.
- Digit outputs:
  - Show the live count except in LAP, where they show the lap latch.
  - Live counting continues underneath during LAP.
  - On LAP -> PAUSE, the outputs switch back to the live count.
- Pausing on the prescaler terminal cycle: if start_stop is detected on the same edge the prescaler reaches DIV-1, the pause takes effect and no tick or advance occurs. Pause wins.

Decomposition:
- Package stopwatch_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, LAP), 2-bit encoding;
  - BCD limit constants (SEC_ONES_MAX=9, SEC_TENS_MAX=5);
  - the function computing the prescaler width, clog2(DIV).
- One sub-module, tick_gen: prescaler with en, clr and tick outputs.
- The FSM, BCD counter and lap latch stay in stopwatch_ctrl.

Test Plan:
- All scenarios use CLK_HZ=10, TICK_HZ=1, so DIV=10.
- Reset release then start_stop pulse -> running=1 the next cycle; the first tick arrives 10 cycles after the state change; sec_ones=1 coincident with tick.
- Run 595 ticks from 0:00 with MAX_MIN=9 -> digits 9:55. Run 5 more ticks -> 0:00, with wrap and tick high together for one cycle.
- At 0:07, lap pulse -> frozen=1 and outputs hold 0:07 for 30 ticks. A second lap pulse -> outputs show 0:37.
- Pause 4 cycles into a second, wait 100 cycles, resume -> the next tick arrives 6 cycles after resume and there are no ticks while paused.
- In PAUSE, clr and start_stop edges in the same cycle -> IDLE with digits 0:00. clr pulse in RUN -> no effect.
- Assert reset mid-RUN at 3:21 while start_stop is held high -> all outputs 0 asynchronously; after release, no spurious start until start_stop falls and rises again.
